hamm_byte_assembler: RTL
========================

// Module: hamm_byte_assembler
// PURPOSE
//  Downstream stage of the Hamming(7,4) decoder. Accepts corrected 4-bit nibbles
//  together with their 3-bit syndromes, and pairs consecutive nibbles into bytes.
//  Bytes are buffered in a small FIFO and presented on a valid/ready interface,
//  each with a flag marking whether any bit was corrected. This bridges the
//  nibble-wide decode path to byte-wide consumers.
// PARAMETERS
//  FIFO_DEPTH  4  byte FIFO entries; power of 2, >=2
//  LOW_FIRST   1  1: first nibble -> byte_data[3:0]; 0: first nibble -> byte_data[7:4]
//  CNT_W       16 width of corrected-error counter (only with HAMM_ERR_COUNT_EN)
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      asynchronous active-low reset
//  nib_valid     in   1      nibble present
//  nib_ready     out  1      nibble accepted when nib_valid & nib_ready
//  nib_data      in   4      corrected data nibble (decoder out)
//  nib_syndrome  in   3      decoder error_index; 3'b000 = no error, 1..7 = corrected bit position
//  flush         in   1      pulse: emit a held half-byte, padded with zero
//  byte_valid    out  1      FIFO head valid
//  byte_ready    in   1      consumer accepts head when byte_valid & byte_ready
//  byte_data     out  8      assembled byte
//  byte_corr     out  1      1 if either nibble of this byte had a nonzero syndrome
//  byte_part     out  1      1 if byte came from flush (missing nibble = 4'h0)
//  err_count     out  CNT_W  corrected-nibble count (HAMM_ERR_COUNT_EN only)
//  err_clr       in   1      synchronous clear of err_count (HAMM_ERR_COUNT_EN only)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, FIFO empty, byte_valid=0, byte_data=0,
//    byte_corr=0, byte_part=0, err_count=0. Any held nibble and FIFO contents are
//    discarded, including mid-byte.
//  - FSM states:
//    IDLE: no nibble held.
//    HOLD: first nibble and its corr bit are latched.
//    IDLE --accept--> HOLD.
//    HOLD --accept or flush push--> IDLE.
//  - nib_ready = (state==IDLE) | ~fifo_full. It is registered-state based only;
//    there is no combinational path from byte_ready.
//  - Second nibble accepted in HOLD: push {byte, corr0|corr1, part=0}.
//    corrN = (syndrome != 0).
//  - flush in HOLD with fifo not full and no nibble accepted that cycle: push the
//    held nibble in its LOW_FIRST lane, other lane 4'h0, with part=1; go to IDLE.
//  - flush in HOLD with fifo full: ignored, and is not remembered.
//  - flush in IDLE: no-op.
//  - flush and nibble accept in the same cycle in HOLD: the normal byte is
//    completed, and flush is ignored.
//  - FIFO is first-word-fall-through: byte_valid = ~empty. Latency is 1 cycle, so
//    the byte is visible the cycle after the second-nibble (or flush) handshake.
//  - Push and pop in the same cycle while full: legal only when nib_ready was
//    already 1; nib_ready does not rise in the same cycle a pop occurs.
//  - byte_data, byte_corr and byte_part hold stable while byte_valid & ~byte_ready.
//  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. full = MSBs differ
//    and LSBs equal.
// CONFIGURATION
//  - HAMM_ERR_COUNT_EN defined:
//    - err_count increments by 1 for each accepted nibble with nonzero syndrome.
//    - err_count saturates at all-ones.
//    - err_clr has priority over a same-cycle increment; the result is 0.
//  - HAMM_ERR_COUNT_EN undefined: err_count and err_clr ports are absent and no
//    counter logic is built.
// STRUCTURE
//  - Package hamm_pkg holds:
//    - NIB_W=4, SYN_W=3, BYTE_W=8
//    - SYN_NONE=3'b000
//    - the FSM state typedef (IDLE, HOLD)
//    - byte_entry_t {data[7:0], corr, part}
//  - One sub-module, hamm_sync_fifo (DEPTH, WIDTH=10): FWFT, push/pop/full/empty,
//    async active-low reset.
//  - The top holds the FSM, the nibble holding register, lane steering and the
//    optional counter.
// TESTING
//  1. Reset, then nibbles 4'h3 (syn 0) and 4'hA (syn 0), LOW_FIRST=1 ->
//     next cycle byte_valid=1, byte_data=8'hA3, byte_corr=0, byte_part=0.
//  2. Nibbles 4'h5 (syn 3'b110) and 4'h1 (syn 0) -> byte_data=8'h15, byte_corr=1;
//     with HAMM_ERR_COUNT_EN, err_count=1.
//  3. byte_ready=0 and 2*FIFO_DEPTH+1 nibbles sent ->
//     - 4 bytes queued, then nib_ready=0 in HOLD;
//     - byte_ready=1 drains in order, with no loss or duplication.
//  4. Flush tests:
//     - Nibble 4'h7 then flush -> byte_data=8'h07, byte_part=1.
//     - Flush in IDLE -> no push.
//     - Flush with same-cycle second nibble 4'h2 -> byte 8'h27, byte_part=0.
//  5. Reset mid-operation:
//     - Hold a nibble with 2 bytes queued, then pulse rst_n low -> byte_valid=0
//       immediately (async).
//     - Next nibbles 4'h1, 4'h2 -> byte_data=8'h21.
//  6. Counter tests (HAMM_ERR_COUNT_EN, CNT_W=2):
//     - 5 errored nibbles -> err_count=2'b11 (saturated).
//     - err_clr with a same-cycle errored nibble -> err_count=0.

Source files
------------

// File: rtl/hamm_pkg.sv
// Purpose: shared types and constants for the Hamming(7,4) nibble-to-byte path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: field widths, the "no error" syndrome code, the assembler FSM state
// type, the FIFO entry layout and the nibble lane-steering helper.
package hamm_pkg;

  localparam int NIB_W  = 4;
  localparam int SYN_W  = 3;
  localparam int BYTE_W = 8;

  localparam logic [SYN_W-1:0] SYN_NONE = 3'b000;

  // IDLE: nothing held; HOLD: first nibble of a byte is waiting for its partner.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } asm_state_t;

  // One queued byte: payload, "some bit was corrected" flag, "flush-padded" flag.
  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              corr;
    logic              part;
  } byte_entry_t;

  localparam int ENTRY_W = $bits(byte_entry_t);

  // Places the first and second nibble into their byte lanes. With low_first
  // set, the first nibble arriving becomes the low half of the byte.
  function automatic logic [BYTE_W-1:0] steer_nibbles(
    input logic             low_first,
    input logic [NIB_W-1:0] first_nib,
    input logic [NIB_W-1:0] second_nib
  );
    logic [BYTE_W-1:0] res;
    if (low_first) res = {second_nib, first_nib};
    else           res = {first_nib, second_nib};
    return res;
  endfunction

endpackage

// File: rtl/hamm_sync_fifo.sv
// Purpose: small synchronous first-word-fall-through FIFO for assembled bytes.
// Latency: a pushed word is visible on rdata the cycle after the push.
// Backpressure: full blocks further pushes (push while full is dropped); pop while empty is ignored.
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata     write strobe and data
//   pop             consume the head word
//   rdata           head word (meaningful only while ~empty)
//   full, empty     occupancy flags, derived from registered pointers only
module hamm_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the index bits match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only observed between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/hamm_byte_assembler.sv
// Purpose: pairs corrected Hamming(7,4) nibbles into bytes with a corrected-bit flag, buffered in a FWFT FIFO.
// Latency: byte visible on byte_* one cycle after the second-nibble (or flush) handshake.
// Backpressure: nib_ready drops only in HOLD with the FIFO full; it depends on registered state, never on byte_ready.
// Ports:
//   clk, rst_n                  rising-edge clock, asynchronous active-low reset
//   nib_valid/nib_ready         nibble handshake; nib_data = corrected nibble,
//   nib_data, nib_syndrome      nib_syndrome = decoder error index (0 = clean)
//   flush                       pulse: emit a held half-byte padded with 4'h0
//   byte_valid/byte_ready       byte handshake on the FIFO head
//   byte_data, byte_corr,       assembled byte, "a bit was corrected" flag,
//   byte_part                   "padded by flush" flag
//   err_count, err_clr          corrected-nibble counter and its clear; present
//                               only when HAMM_ERR_COUNT_EN is defined
module hamm_byte_assembler
  import hamm_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit LOW_FIRST  = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             nib_valid,
  output logic             nib_ready,
  input  logic [NIB_W-1:0] nib_data,
  input  logic [SYN_W-1:0] nib_syndrome,
  input  logic             flush,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic [BYTE_W-1:0] byte_data,
  output logic             byte_corr,
  output logic             byte_part
`ifdef HAMM_ERR_COUNT_EN
  ,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clr
`endif
);

  asm_state_t       state_q;
  asm_state_t       state_d;
  logic [NIB_W-1:0] hold_nib_q;
  logic             hold_corr_q;
  logic             load_hold;

  logic             nib_accept;
  logic             nib_corr;

  logic             fifo_push;
  byte_entry_t      fifo_wentry;
  logic [ENTRY_W-1:0] fifo_rdata;
  byte_entry_t      head;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;

  // In IDLE an accepted nibble only lands in the holding register, so the
  // FIFO level does not matter; only the second nibble of a byte needs space.
  assign nib_ready  = (state_q == IDLE) | ~fifo_full;
  assign nib_accept = nib_valid & nib_ready;
  assign nib_corr   = (nib_syndrome != SYN_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    load_hold   = 1'b0;
    fifo_push   = 1'b0;
    fifo_wentry = '0;
    case (state_q)
      IDLE: begin
        // A flush with nothing held has nothing to emit.
        if (nib_accept) begin
          load_hold = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (nib_accept) begin
          // A real second nibble wins over a same-cycle flush.
          fifo_push        = 1'b1;
          fifo_wentry.data = steer_nibbles(LOW_FIRST, hold_nib_q, nib_data);
          fifo_wentry.corr = hold_corr_q | nib_corr;
          fifo_wentry.part = 1'b0;
          state_d          = IDLE;
        end else if (flush && !fifo_full) begin
          // Flush against a full FIFO is dropped, not deferred.
          fifo_push        = 1'b1;
          fifo_wentry.data = steer_nibbles(LOW_FIRST, hold_nib_q, '0);
          fifo_wentry.corr = hold_corr_q;
          fifo_wentry.part = 1'b1;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_nib_q  <= '0;
      hold_corr_q <= 1'b0;
    end else if (load_hold) begin
      hold_nib_q  <= nib_data;
      hold_corr_q <= nib_corr;
    end
  end

  assign fifo_pop = byte_valid & byte_ready;

  hamm_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wentry),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head       = byte_entry_t'(fifo_rdata);
  assign byte_valid = ~fifo_empty;

  // Head fields are forced to zero while empty so the outputs read as zero
  // out of reset even though the FIFO storage itself is not reset.
  assign byte_data = byte_valid ? head.data : '0;
  assign byte_corr = byte_valid & head.corr;
  assign byte_part = byte_valid & head.part;

`ifdef HAMM_ERR_COUNT_EN
  // Counts accepted nibbles carrying a correction; sticks at all-ones, and a
  // clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (nib_accept && nib_corr && !(&err_count)) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule
